// File: rtl/bin2bcd_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_seq_if
// Purpose  : Valid/ready handshake bundle for the sequential binary-to-BCD
//            converter. The input side carries the operand. The output side
//            carries the packed BCD result with its sign and overflow flags.
// Signals  : in_valid/in_ready/bin_in     - operand handshake
//            out_valid/out_ready          - result handshake
//            bcd_out/sign_out/ovf         - result fields
// Modports : master - producer/consumer around the converter
//            slave  - the converter itself
// Revision : 1.0 - initial release
// ============================================================================
interface bin2bcd_seq_if #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [BIN_W-1:0]      bin_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  sign_out;
    logic                  ovf;

    modport master (
        output in_valid, bin_in, out_ready,
        input  in_ready, out_valid, bcd_out, sign_out, ovf
    );

    modport slave (
        input  in_valid, bin_in, out_ready,
        output in_ready, out_valid, bcd_out, sign_out, ovf
    );
endinterface
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_seq
// Purpose  : Sequential shift-and-add-3 (double-dabble) binary-to-BCD
//            converter. It handles one input bit per clock and has an
//            optional two's-complement mode that converts the magnitude.
// Ports    : clk  - rising-edge clock
//            rst  - asynchronous active-high reset
//            bus  - bin2bcd_seq_if.slave (operand and result handshakes)
// Params   : BIN_W (>=2), DIGITS (>=1), SIGNED (0/1)
// Revision : 1.0 - initial release
// ============================================================================
module bin2bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3,
    parameter int SIGNED = 0
) (
    input  wire logic       clk,
    input  wire logic       rst,
    bin2bcd_seq_if.slave    bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [BIN_W-1:0]   r_shift;
    logic [BCD_W-1:0]   r_bcd;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;
    logic               r_sign;
    logic [BCD_W-1:0]   r_bcd_out;
    logic               r_sign_out;
    logic               r_ovf_out;

    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_neg;
    logic [BIN_W-1:0]   w_mag;
    logic [BCD_W-1:0]   w_adj;
    logic [BCD_W-1:0]   w_bcd_next;
    logic               w_ovf_next;
    logic               w_last;

    // Negation in BIN_W bits maps -2^(BIN_W-1) onto itself. Read as unsigned,
    // that is exactly +2^(BIN_W-1), so no extra magnitude bit is needed.
    assign w_neg = (SIGNED != 0) && bus.bin_in[BIN_W-1];
    assign w_mag = w_neg ? -bus.bin_in : bus.bin_in;

    // Add 3 to each digit >= 5 before the shift. The add is 4-bit per digit
    // with no carry into the neighbour.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        assign w_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd5) ?
                                  r_bcd[4*gi +: 4] + 4'd3 : r_bcd[4*gi +: 4];
    end

    assign w_bcd_next = {w_adj[BCD_W-2:0], r_shift[BIN_W-1]};
    // The bit shifted out of the top digit would belong to a digit beyond
    // DIGITS. It is remembered as a sticky overflow, and the low digits stay
    // correct modulo 10^DIGITS.
    assign w_ovf_next = r_ovf | w_adj[BCD_W-1];
    assign w_last     = (r_cnt == c_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = S_IDLE;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready   = 1'b1;
                w_state_next = bus.in_valid ? S_CONV : S_IDLE;
            end
            S_CONV: begin
                w_state_next = w_last ? S_DONE : S_CONV;
            end
            S_DONE: begin
                w_out_valid  = 1'b1;
                w_state_next = bus.out_ready ? S_IDLE : S_DONE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift    <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_sign     <= 1'b0;
            r_bcd_out  <= '0;
            r_sign_out <= 1'b0;
            r_ovf_out  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_shift <= w_mag;
                        r_sign  <= w_neg;
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                        r_ovf   <= 1'b0;
                    end
                end
                S_CONV: begin
                    r_bcd   <= w_bcd_next;
                    r_shift <= {r_shift[BIN_W-2:0], 1'b0};
                    r_ovf   <= w_ovf_next;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_bcd_out  <= w_bcd_next;
                        r_sign_out <= r_sign;
                        r_ovf_out  <= w_ovf_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.bcd_out   = r_bcd_out;
    assign bus.sign_out  = r_sign_out;
    assign bus.ovf       = r_ovf_out;
endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin2bcd_seq
// Purpose  : Directed self-checking bench for bin2bcd_seq. It runs three
//            instances in lock-step from the same stimulus:
//            A unsigned with 3 digits, B signed with 3 digits, and
//            C unsigned with 2 digits.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bin2bcd_seq;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    int   cyc;
    int   ov_cyc;
    int   prev_cyc;

    bin2bcd_seq_if #(.BIN_W(8), .DIGITS(3)) ia ();
    bin2bcd_seq_if #(.BIN_W(8), .DIGITS(3)) ib ();
    bin2bcd_seq_if #(.BIN_W(8), .DIGITS(2)) ic ();

    bin2bcd_seq #(.BIN_W(8), .DIGITS(3), .SIGNED(0)) u_a (.clk(clk), .rst(rst), .bus(ia));
    bin2bcd_seq #(.BIN_W(8), .DIGITS(3), .SIGNED(1)) u_b (.clk(clk), .rst(rst), .bus(ib));
    bin2bcd_seq #(.BIN_W(8), .DIGITS(2), .SIGNED(0)) u_c (.clk(clk), .rst(rst), .bus(ic));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [7:0] d);
        ia.in_valid = v; ia.bin_in = d;
        ib.in_valid = v; ib.bin_in = d;
        ic.in_valid = v; ic.bin_in = d;
    endtask

    task automatic set_ordy(input logic r);
        ia.out_ready = r; ib.out_ready = r; ic.out_ready = r;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".a_rdy"}, ia.in_ready, 1);
        chk({tag, ".a_ov"},  ia.out_valid, 0);
        chk({tag, ".a_bcd"}, ia.bcd_out, 0);
        chk({tag, ".b_bcd"}, ib.bcd_out, 0);
        chk({tag, ".b_sign"}, ib.sign_out, 0);
        chk({tag, ".c_bcd"}, ic.bcd_out, 0);
        chk({tag, ".c_ovf"}, ic.ovf, 0);
    endtask

    // Called at a negedge. Pulses in_valid for one cycle and checks the
    // 8-cycle latency and all three results. It then checks the transfer and
    // returns one negedge after the transfer edge.
    task automatic conv(input logic [7:0] v, input logic [11:0] ea,
                        input logic [11:0] eb, input logic eb_s,
                        input logic [7:0] ec, input logic ec_o);
        logic early;
        string t;
        t = $sformatf("conv%0d", v);
        drive(1'b1, v);
        @(negedge clk);
        drive(1'b0, 8'h00);
        chk({t, ".busy_rdy"}, ia.in_ready, 0);
        early = 1'b0;
        repeat (7) begin
            @(negedge clk);
            if (ia.out_valid || ib.out_valid || ic.out_valid) early = 1'b1;
        end
        chk({t, ".early_ov"}, early, 0);
        @(negedge clk);
        ov_cyc = cyc;
        chk({t, ".a_ov"},   ia.out_valid, 1);
        chk({t, ".b_ov"},   ib.out_valid, 1);
        chk({t, ".c_ov"},   ic.out_valid, 1);
        chk({t, ".a_bcd"},  ia.bcd_out, ea);
        chk({t, ".a_sign"}, ia.sign_out, 0);
        chk({t, ".a_ovf"},  ia.ovf, 0);
        chk({t, ".b_bcd"},  ib.bcd_out, eb);
        chk({t, ".b_sign"}, ib.sign_out, eb_s);
        chk({t, ".c_bcd"},  ic.bcd_out, ec);
        chk({t, ".c_ovf"},  ic.ovf, ec_o);
        chk({t, ".c_sign"}, ic.sign_out, 0);
        @(negedge clk);
        chk({t, ".post_ov"},  ia.out_valid, 0);
        chk({t, ".post_rdy"}, ia.in_ready, 1);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        cyc      = 0;
        ov_cyc   = 0;
        prev_cyc = 0;
        rst      = 1'b1;
        drive(1'b0, 8'h00);
        set_ordy(1'b1);
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("idle_rdy", ia.in_ready, 1);

        // Full-scale unsigned value, which overflows the 2-digit instance.
        conv(8'd255, 12'h255, 12'h001, 1'b1, 8'h55, 1'b1);

        // Back-to-back sweep. Result pulses are 10 cycles apart.
        prev_cyc = ov_cyc;
        conv(8'd0,   12'h000, 12'h000, 1'b0, 8'h00, 1'b0);
        chk("spacing0", ov_cyc - prev_cyc, 10); prev_cyc = ov_cyc;
        conv(8'd9,   12'h009, 12'h009, 1'b0, 8'h09, 1'b0);
        chk("spacing9", ov_cyc - prev_cyc, 10); prev_cyc = ov_cyc;
        conv(8'd10,  12'h010, 12'h010, 1'b0, 8'h10, 1'b0);
        chk("spacing10", ov_cyc - prev_cyc, 10); prev_cyc = ov_cyc;
        conv(8'd99,  12'h099, 12'h099, 1'b0, 8'h99, 1'b0);
        chk("spacing99", ov_cyc - prev_cyc, 10); prev_cyc = ov_cyc;
        conv(8'd100, 12'h100, 12'h100, 1'b0, 8'h00, 1'b1);
        chk("spacing100", ov_cyc - prev_cyc, 10); prev_cyc = ov_cyc;
        conv(8'd199, 12'h199, 12'h057, 1'b1, 8'h99, 1'b1);
        chk("spacing199", ov_cyc - prev_cyc, 10);

        // Signed corner cases: most negative value, and most positive value.
        conv(8'h80, 12'h128, 12'h128, 1'b1, 8'h28, 1'b1);
        conv(8'h7F, 12'h127, 12'h127, 1'b0, 8'h27, 1'b1);

        // Backpressure: results held, new data refused.
        set_ordy(1'b0);
        drive(1'b1, 8'd123);
        @(negedge clk);
        drive(1'b0, 8'h00);
        repeat (8) @(negedge clk);
        chk("bp.ov", ia.out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            drive((i % 2) == 0, 8'd55);
            @(negedge clk);
            chk($sformatf("bp%0d.ov", i),    ia.out_valid, 1);
            chk($sformatf("bp%0d.rdy", i),   ia.in_ready, 0);
            chk($sformatf("bp%0d.a_bcd", i), ia.bcd_out, 12'h123);
            chk($sformatf("bp%0d.c_bcd", i), ic.bcd_out, 8'h23);
            chk($sformatf("bp%0d.c_ovf", i), ic.ovf, 1);
        end
        drive(1'b0, 8'h00);
        set_ordy(1'b1);
        @(negedge clk);
        chk("bp.xfer_ov",  ia.out_valid, 0);
        chk("bp.xfer_rdy", ia.in_ready, 1);
        chk("bp.held_bcd", ia.bcd_out, 12'h123);
        @(negedge clk);
        chk("bp.not_taken", ia.in_ready, 1);

        conv(8'hF6, 12'h246, 12'h010, 1'b1, 8'h46, 1'b1);

        // Asynchronous reset during the 4th conversion cycle.
        drive(1'b1, 8'd200);
        @(negedge clk);
        drive(1'b0, 8'h00);
        repeat (3) @(negedge clk);
        chk("mid.busy", ia.in_ready, 0);
        #1 rst = 1'b1;
        #1;
        chk_reset_vals("midrst");
        chk("midrst.c_ov", ic.out_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        conv(8'd42, 12'h042, 12'h042, 1'b0, 8'h42, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm. It processes one input bit per clock and supports configurable input width, BCD digit count and an optional two's-complement signed mode. Valid/ready handshakes on input and output let it sit between a binary datapath and a decimal display or formatting stage. It is the general successor to the team's fixed 4-bit BCD converter.

## Interface
- `BIN_W`, default 8: input width in bits; must be ≥ 2.
- `DIGITS`, default 3: number of BCD digits in the result; must be ≥ 1.
- `SIGNED`, default 0: 1 = input is two's complement and the magnitude is converted; 0 = input is unsigned.
- `clk` in, 1: single clock; all state updates on the rising edge.
- `rst` in, 1: asynchronous, active-high reset.
- `in_valid` in, 1: `bin_in` holds a value to convert.
- `in_ready` out, 1: converter can accept input.
- `bin_in` in, `BIN_W`: binary operand.
- `out_valid` out, 1: result fields are valid and held stable.
- `out_ready` in, 1: consumer accepts the result.
- `bcd_out` out, `4*DIGITS`: packed BCD result; digit 0 (units) is in `[3:0]`.
- `sign_out` out, 1: 1 = negative input. Constant 0 when `SIGNED=0`.
- `ovf` out, 1: the value needed more than `DIGITS` digits.

## Operation
- States:
  - IDLE: `in_ready=1`.
  - CONV: `BIN_W` iterations.
  - DONE: `out_valid=1`.
- IDLE to CONV happens on the edge where `in_valid && in_ready` is true. On that edge the block:
  - loads the shift register with `bin_in`, or with |`bin_in`| when `SIGNED=1` and the MSB is 1;
  - captures the sign;
  - clears the BCD accumulator, the iteration counter and the overflow flag.
- Each CONV edge performs one combined iteration:
  - every digit ≥ 5 gets +3 (4-bit add, no carry between digits);
  - the concatenation {digits, shift register} shifts left by 1;
  - the bit leaving the top digit is ORed into the sticky `ovf`;
  - the counter increments.
- Magnitude rule: the most negative value −2^(BIN_W−1) converts to +2^(BIN_W−1). The magnitude is held in `BIN_W` bits with no loss.
- On the `BIN_W`-th CONV edge: go to DONE, register `bcd_out`, `sign_out` and `ovf`, and assert `out_valid`.
- DONE to IDLE happens on the edge where `out_valid && out_ready`. At that point `out_valid` drops.
- While `out_valid=1` and `out_ready=0`, `bcd_out`, `sign_out` and `ovf` stay stable.
- Outputs keep their last values in IDLE and CONV. Only `out_valid` qualifies them.
- Overflow: when `ovf=1`, `bcd_out` equals (magnitude mod 10^DIGITS), i.e. the low `DIGITS` decimal digits.
- `in_valid` is ignored during CONV and DONE (`in_ready=0`). No input is queued.
- `rst` asserted at any time, including mid-CONV or in DONE, forces IDLE immediately:
  - `in_ready=1`;
  - `out_valid=0`, `bcd_out=0`, `sign_out=0`, `ovf=0`;
  - internal registers cleared;
  - any partial conversion is discarded.
- Illegal state encodings recover to IDLE on the next edge.

## Timing
- Reset values: `in_ready=1`, `out_valid=0`, `bcd_out=0`, `sign_out=0`, `ovf=0`.
- Latency: the acceptance edge is E0, and `out_valid` rises after edge E`BIN_W`. For the defaults that is 8 cycles.
- Throughput with `out_ready` tied high: one conversion per `BIN_W+2` cycles (accept, `BIN_W` iterations, transfer).
- `in_ready` and `out_valid` are registered-state decodes. There is no combinational path from `in_valid` or `out_ready` to any output.
- The counter width is ceil(log2(`BIN_W`+1)) bits. It never wraps within a conversion.

## Test plan
- Defaults, unsigned: `bin_in`=255 with `in_valid` pulsed for 1 cycle, `out_ready`=1 → `out_valid` exactly 8 cycles after acceptance, `bcd_out`=0x255, `ovf`=0, `sign_out`=0, then `in_ready`=1 on the following cycle.
- Sweep: `bin_in`=0, 9, 10, 99, 100, 199 back-to-back → `bcd_out`=0x000, 0x009, 0x010, 0x099, 0x100, 0x199. The spacing between `out_valid` pulses is 10 cycles.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid` while toggling `in_valid` with new data → outputs stable, `in_ready`=0, the new data is not taken; the transfer occurs on the first cycle with `out_ready`=1.
- `SIGNED`=1, `BIN_W`=8: inputs 0x80 and 0xF6 → `sign_out`=1 with `bcd_out`=0x128 for the first and 0x010 for the second; input 0x7F → `sign_out`=0, `bcd_out`=0x127.
- Overflow with `DIGITS`=2, `BIN_W`=8: `bin_in`=255 → `ovf`=1, `bcd_out`=0x55; `bin_in`=99 → `ovf`=0, `bcd_out`=0x99.
- Reset mid-operation: assert `rst` on the 4th CONV cycle, release, then convert 42 → all outputs go to reset values immediately, and the subsequent result is 0x042 with full 8-cycle latency and no stale `ovf` or sign.
